// File: rtl/toggle_reg_bank.sv
// Mode-selectable bank of T flip-flops (toggle / load / T-chain count / masked clear) with change, wrap and event-count status.
// All outputs registered, 1-cycle latency; no backpressure, en=0 freezes the bank.
module toggle_reg_bank #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          CNT_WIDTH = 16,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [1:0]           mode,
  input  logic [WIDTH-1:0]     data,
  output logic [WIDTH-1:0]     data_out,
  output logic                 changed,
  output logic                 tc,
  output logic [CNT_WIDTH-1:0] toggle_cnt
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_COUNT  = 2'b10,
    MODE_CLEAR  = 2'b11
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  mode_e            mode_sel;
  logic [WIDTH-1:0] t_vec;
  logic [WIDTH-1:0] next_q;
  logic             carry;
  logic             next_changed;
  logic             next_tc;

  assign mode_sel = mode_e'(mode);

  // Every mode is expressed as a toggle vector so the bank stays a pure T-flop array.
  always_comb begin
    t_vec = '0;
    carry = 1'b0;
    case (mode_sel)
      MODE_TOGGLE: t_vec = data;
      MODE_LOAD:   t_vec = data_out ^ data;
      MODE_COUNT: begin
        carry = data[0];
        for (int i = 0; i < int'(WIDTH); i++) begin
          t_vec[i] = carry;
          carry    = carry & data_out[i];
        end
      end
      MODE_CLEAR:  t_vec = data_out & data;
      default:     t_vec = '0;
    endcase
  end

  assign next_q       = data_out ^ t_vec;
  assign next_changed = |t_vec;
  assign next_tc      = (mode_sel == MODE_COUNT) && data[0] && (&data_out);

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= RESET_VAL;
      changed    <= 1'b0;
      tc         <= 1'b0;
      toggle_cnt <= '0;
    end else if (!en) begin
      changed <= 1'b0;
      tc      <= 1'b0;
    end else begin
      data_out <= next_q;
      changed  <= next_changed;
      tc       <= next_tc;
      if (next_changed && (toggle_cnt != CNT_MAX)) begin
        toggle_cnt <= toggle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_toggle_reg_bank.sv
// Bench for toggle_reg_bank: directed plan plus random stimulus against an arithmetic reference model.
module tb_toggle_reg_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  data;
  logic [7:0]  data_out, sat_data_out;
  logic        changed, sat_changed;
  logic        tc, sat_tc;
  logic [15:0] toggle_cnt;
  logic [1:0]  sat_cnt;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_q, m_cnt, m_sat;
  bit m_chg, m_tc;

  always #5 clk = ~clk;

  toggle_reg_bank #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data(data),
    .data_out(data_out), .changed(changed), .tc(tc), .toggle_cnt(toggle_cnt)
  );

  toggle_reg_bank #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data(data),
    .data_out(sat_data_out), .changed(sat_changed), .tc(sat_tc), .toggle_cnt(sat_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit e, input int md, input int d);
    int nxt;
    reset = r;
    en    = e;
    mode  = 2'(md);
    data  = 8'(d);
    if (r) begin
      m_q = 0; m_chg = 0; m_tc = 0; m_cnt = 0; m_sat = 0;
    end else if (!e) begin
      m_chg = 0; m_tc = 0;
    end else begin
      case (md)
        0:       nxt = m_q ^ d;
        1:       nxt = d;
        2:       nxt = (m_q + (d % 2)) % 256;
        default: nxt = m_q & ~d & 255;
      endcase
      m_tc  = (md == 2) && (d % 2 == 1) && (m_q == 255);
      m_chg = (nxt != m_q);
      if (m_chg) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_sat < 3) m_sat++;
      end
      m_q = nxt;
    end
    @(posedge clk);
    #1;
    check_val("data_out",   32'(data_out),     32'(m_q));
    check_val("changed",    32'(changed),      32'(m_chg));
    check_val("tc",         32'(tc),           32'(m_tc));
    check_val("toggle_cnt", 32'(toggle_cnt),   32'(m_cnt));
    check_val("sat_cnt",    32'(sat_cnt),      32'(m_sat));
    check_val("sat_q",      32'(sat_data_out), 32'(m_q));
  endtask

  initial begin
    reset = 1'b1; en = 1'b1; mode = 2'b00; data = 8'hFF;

    // reset with toggle activity that must be ignored
    step(1, 1, 0, 8'hFF);
    step(1, 1, 0, 8'hFF);
    check_val("rst_q", 32'(data_out), 32'h00);
    check_val("rst_cnt", 32'(toggle_cnt), 32'h0);

    // toggle A5 three times, then a zero mask
    step(0, 1, 0, 8'hA5);
    check_val("tog1", 32'(data_out), 32'hA5);
    step(0, 1, 0, 8'hA5);
    check_val("tog2", 32'(data_out), 32'h00);
    step(0, 1, 0, 8'hA5);
    check_val("tog3", 32'(data_out), 32'hA5);
    check_val("tog_cnt", 32'(toggle_cnt), 32'd3);
    step(0, 1, 0, 8'h00);
    check_val("tog_hold", 32'(data_out), 32'hA5);
    check_val("tog_hold_chg", 32'(changed), 32'd0);

    // load / clear / repeated clear
    step(0, 1, 1, 8'h3C);
    check_val("load", 32'(data_out), 32'h3C);
    step(0, 1, 3, 8'h0C);
    check_val("clear", 32'(data_out), 32'h30);
    step(0, 1, 3, 8'h0C);
    check_val("clear_again_chg", 32'(changed), 32'd0);

    // count across the wrap
    step(0, 1, 1, 8'hFE);
    step(0, 1, 2, 8'h01);
    check_val("cnt_ff", 32'(data_out), 32'hFF);
    check_val("cnt_ff_tc", 32'(tc), 32'd0);
    step(0, 1, 2, 8'h01);
    check_val("cnt_wrap", 32'(data_out), 32'h00);
    check_val("cnt_wrap_tc", 32'(tc), 32'd1);
    step(0, 1, 2, 8'h01);
    check_val("cnt_01", 32'(data_out), 32'h01);
    check_val("cnt_01_tc", 32'(tc), 32'd0);
    step(0, 1, 2, 8'hFE);
    check_val("cnt_hold", 32'(data_out), 32'h01);

    // enable hold, then reset while disabled
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'h55);
    check_val("en_hold", 32'(data_out), 32'h01);
    step(1, 0, 1, 8'h55);
    check_val("rst_en0", 32'(data_out), 32'h00);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 8'h01);
      check_val("sat_seq", 32'(sat_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    step(1, 1, 0, 8'h01);
    check_val("sat_rst", 32'(sat_cnt), 32'd0);

    // random traffic, with wrap-prone loads mixed in
    for (int i = 0; i < 400; i++) begin
      int md, d;
      bit r, e;
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 7) != 0);
      md = int'($urandom_range(0, 3));
      d  = int'($urandom_range(0, 255));
      if (md == 1 && $urandom_range(0, 2) == 0) d = 8'hFF;
      if (md == 2 && $urandom_range(0, 3) != 0) d = d | 1;
      step(r, e, md, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
